// File: rtl/nano_bus_pkg.sv
// Shared types and defaults for the nano2 data-bus arbiter.
package nano_bus_pkg;

    localparam int NANO_WIDTHA = 16;
    localparam int NANO_WIDTHD = 32;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        LOCKED
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    always_comb begin
        logic          found;
        logic [PW-1:0] j;
        found = 1'b0;
        gnt   = '0;
        idx   = ptr;
        j     = '0;
        for (int k = 1; k <= N; k++) begin
            j = PW'((int'(ptr) + k) % N);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the nano2 data-bus slave side, with per-master
// lock and a waitrequest watchdog that aborts stuck transfers.
module bus_arbiter
    import nano_bus_pkg::*;
#(
    parameter int NMASTERS = 2,
    parameter int WIDTHA   = NANO_WIDTHA,
    parameter int WIDTHD   = NANO_WIDTHD,
    parameter int TIMEOUT  = 255,
    parameter logic [WIDTHD-1:0] ERR_DATA = WIDTHD'(ERR_DATA_DEFAULT)
) (
    input  logic                       clock,
    input  logic                       sreset,
    input  logic [NMASTERS*WIDTHA-1:0] m_address,
    input  logic [NMASTERS*WIDTHD-1:0] m_writedata,
    input  logic [NMASTERS-1:0]        m_read,
    input  logic [NMASTERS-1:0]        m_write,
    input  logic [NMASTERS-1:0]        m_lock,
    output logic [WIDTHD-1:0]          m_readdata,
    output logic [NMASTERS-1:0]        m_waitrequest,
    output logic [WIDTHA-1:0]          s_address,
    output logic [WIDTHD-1:0]          s_writedata,
    output logic                       s_read,
    output logic                       s_write,
    input  logic [WIDTHD-1:0]          s_readdata,
    input  logic                       s_waitrequest,
    output logic [NMASTERS-1:0]        grant,
    output logic                       err_timeout,
    input  logic                       err_clear
);

    localparam int PW  = $clog2(NMASTERS);
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t          state;
    logic [NMASTERS-1:0] req;
    logic [NMASTERS-1:0] pick;
    logic [PW-1:0]       pick_idx;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       g_idx;
    logic [WDW-1:0]      wd_cnt;
    logic                own_rd;
    logic                own_wr;
    logic                own_req;
    logic                own_lock;
    logic                active;
    logic                abort;
    logic                done;

    assign req = m_read | m_write;

    rr_arbiter #(
        .N  (NMASTERS),
        .PW (PW)
    ) u_rr (
        .req (req),
        .ptr (ptr),
        .gnt (pick),
        .idx (pick_idx)
    );

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NMASTERS; i++)
            if (grant[i]) g_idx = PW'(i);
    end

    assign own_rd   = |(m_read & grant);
    assign own_wr   = |(m_write & grant);
    assign own_lock = |(m_lock & grant);
    assign own_req  = own_rd | own_wr;

    // A locked owner that requests again is forwarded in the same cycle.
    assign active = (state == BUSY) || (state == LOCKED && own_req);
    assign abort  = (TIMEOUT > 0) && active
                    && (wd_cnt == WDW'(TIMEOUT));

    assign s_read      = active & ~abort & own_rd;
    assign s_write     = active & ~abort & own_wr;
    assign s_address   = m_address[g_idx*WIDTHA +: WIDTHA];
    assign s_writedata = m_writedata[g_idx*WIDTHD +: WIDTHD];
    assign done        = (s_read | s_write) & ~s_waitrequest;

    assign m_readdata = (abort && own_rd) ? ERR_DATA : s_readdata;

    always_comb begin
        m_waitrequest = '0;
        for (int i = 0; i < NMASTERS; i++)
            m_waitrequest[i] = req[i]
                & (~grant[i] | (s_waitrequest & ~abort));
    end

    always_ff @(posedge clock) begin
        if (sreset) begin
            state       <= IDLE;
            grant       <= '0;
            ptr         <= PW'(NMASTERS - 1);
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (abort)
                err_timeout <= 1'b1;
            else if (err_clear)
                err_timeout <= 1'b0;

            unique case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (|req) begin
                        grant <= pick;
                        ptr   <= pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY, LOCKED: begin
                    if (abort) begin
                        state  <= IDLE;
                        grant  <= '0;
                        wd_cnt <= '0;
                    end else if (own_req && !done) begin
                        state  <= BUSY;
                        wd_cnt <= wd_cnt + WDW'(s_waitrequest);
                    end else if (own_lock) begin
                        state  <= LOCKED;
                        wd_cnt <= '0;
                    end else begin
                        state  <= IDLE;
                        grant  <= '0;
                        wd_cnt <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    grant  <= '0;
                    wd_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter with two masters and TIMEOUT=8.
// Slave completions are matched against transfers queued at drive time.
module tb_bus_arbiter;

    localparam int NM = 2;
    localparam int WA = 16;
    localparam int WD = 32;

    logic             clock = 1'b0;
    logic             sreset;
    logic [NM*WA-1:0] m_address;
    logic [NM*WD-1:0] m_writedata;
    logic [NM-1:0]    m_read;
    logic [NM-1:0]    m_write;
    logic [NM-1:0]    m_lock;
    logic [WD-1:0]    m_readdata;
    logic [NM-1:0]    m_waitrequest;
    logic [WA-1:0]    s_address;
    logic [WD-1:0]    s_writedata;
    logic             s_read;
    logic             s_write;
    logic [WD-1:0]    s_readdata;
    logic             s_waitrequest;
    logic [NM-1:0]    grant;
    logic             err_timeout;
    logic             err_clear;

    typedef struct {
        logic [1:0]  gnt;
        logic [15:0] addr;
        logic        wr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk;
    int   n_fail;
    int   stall_cfg;
    int   wcnt;
    int   st;

    bus_arbiter #(
        .NMASTERS (NM),
        .WIDTHA   (WA),
        .WIDTHD   (WD),
        .TIMEOUT  (8)
    ) dut (
        .clock         (clock),
        .sreset        (sreset),
        .m_address     (m_address),
        .m_writedata   (m_writedata),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_lock        (m_lock),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .s_address     (s_address),
        .s_writedata   (s_writedata),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .grant         (grant),
        .err_timeout   (err_timeout),
        .err_clear     (err_clear)
    );

    always #5 clock = ~clock;

    // Slave model: stalls each access stall_cfg cycles, data from address.
    assign s_readdata    = {16'hA5A5, s_address};
    assign s_waitrequest = (s_read | s_write) && (wcnt < stall_cfg);

    always @(posedge clock)
        wcnt <= ((s_read | s_write) && s_waitrequest) ? wcnt + 1 : 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void expect_xfer(input logic [1:0] g,
                                        input logic [15:0] a,
                                        input logic wr,
                                        input logic [31:0] d);
        exp_t e;
        e.gnt  = g;
        e.addr = a;
        e.wr   = wr;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    always @(negedge clock) begin
        if (!sreset && (s_read || s_write) && !s_waitrequest) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_done", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_grant", 32'(grant), 32'(mon_e.gnt));
                check("sb_addr", 32'(s_address), 32'(mon_e.addr));
                check("sb_write", 32'(s_write), 32'(mon_e.wr));
                if (mon_e.wr)
                    check("sb_wdata", s_writedata, mon_e.data);
                else
                    check("sb_rdata", m_readdata, mon_e.data);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int m, output int stalls);
        bit fin;
        fin    = 1'b0;
        stalls = 0;
        for (int k = 0; k < 40 && !fin; k++) begin
            @(negedge clock);
            if (m_waitrequest[m]) stalls++;
            else fin = 1'b1;
        end
        if (!fin)
            check("wait_bound", 32'(m_waitrequest[m]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        sreset      = 1'b1;
        m_address   = '0;
        m_writedata = '0;
        m_read      = '0;
        m_write     = '0;
        m_lock      = '0;
        err_clear   = 1'b0;
        stall_cfg   = 0;
        step();
        step();
        sreset = 1'b0;
        @(negedge clock);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_read", 32'(s_read), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_mwr", 32'(m_waitrequest), 32'd0);

        // single read, slave stalls two cycles
        step();
        stall_cfg = 2;
        m_address[0 +: WA] = 16'h0400;
        m_read = 2'b01;
        expect_xfer(2'b01, 16'h0400, 1'b0, 32'hA5A5_0400);
        @(negedge clock);
        check("t1_arb_grant", 32'(grant), 32'd0);
        check("t1_arb_mwr", 32'(m_waitrequest), 32'd1);
        @(negedge clock);
        check("t1_grant", 32'(grant), 32'd1);
        check("t1_s_read", 32'(s_read), 32'd1);
        check("t1_s_addr", 32'(s_address), 32'h400);
        wait_done(0, st);
        check("t1_stalls", 32'(st + 2), 32'd3);
        step();
        m_read = '0;
        @(negedge clock);
        check("t1_release", 32'(grant), 32'd0);

        // both masters request continuously from reset
        step();
        sreset = 1'b1;
        step();
        sreset    = 1'b0;
        stall_cfg = 0;
        m_address = {16'h0020, 16'h0010};
        m_read    = 2'b11;
        expect_xfer(2'b01, 16'h0010, 1'b0, 32'hA5A5_0010);
        expect_xfer(2'b10, 16'h0020, 1'b0, 32'hA5A5_0020);
        expect_xfer(2'b01, 16'h0010, 1'b0, 32'hA5A5_0010);
        expect_xfer(2'b10, 16'h0020, 1'b0, 32'hA5A5_0020);
        @(negedge clock);
        @(negedge clock);
        check("t2_loser_stall", 32'(m_waitrequest), 32'd2);
        #1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(negedge clock);
            #1;
        end
        check("t2_sb_drain", 32'(exp_q.size()), 32'd0);
        step();
        m_read = '0;

        // m1 locked across two writes while m0 waits
        step();
        m_address[WA +: WA]   = 16'h0030;
        m_writedata[WD +: WD] = 32'h1111_0001;
        m_write = 2'b10;
        m_lock  = 2'b10;
        expect_xfer(2'b10, 16'h0030, 1'b1, 32'h1111_0001);
        expect_xfer(2'b10, 16'h0032, 1'b1, 32'h1111_0002);
        expect_xfer(2'b01, 16'h0040, 1'b0, 32'hA5A5_0040);
        @(negedge clock);
        step();
        m_address[0 +: WA] = 16'h0040;
        m_read = 2'b01;
        @(negedge clock);
        check("t3_m0_waits", 32'(m_waitrequest), 32'd1);
        step();
        m_address[WA +: WA]   = 16'h0032;
        m_writedata[WD +: WD] = 32'h1111_0002;
        @(negedge clock);
        check("t3_fwd_grant", 32'(grant), 32'd2);
        check("t3_fwd_write", 32'(s_write), 32'd1);
        step();
        m_write = '0;
        @(negedge clock);
        check("t3_lock_hold", 32'(grant), 32'd2);
        check("t3_lock_idle", 32'(s_read), 32'd0);
        check("t3_lock_mwr", 32'(m_waitrequest), 32'd1);
        step();
        m_lock = '0;
        wait_done(0, st);
        check("t3_m0_wait", 32'(st), 32'd2);
        step();
        m_read = '0;
        @(negedge clock);
        check("t3_sb_drain", 32'(exp_q.size()), 32'd0);

        // watchdog abort on a stuck read
        step();
        stall_cfg = 1000;
        m_address[0 +: WA] = 16'h0050;
        m_read = 2'b01;
        wait_done(0, st);
        check("t4_stalls", 32'(st), 32'd9);
        check("t4_err_data", m_readdata, 32'hDEAD_BEEF);
        check("t4_s_read", 32'(s_read), 32'd0);
        check("t4_grant", 32'(grant), 32'd1);
        step();
        m_read = '0;
        @(negedge clock);
        check("t4_err_set", 32'(err_timeout), 32'd1);
        check("t4_idle", 32'(grant), 32'd0);
        repeat (3) step();
        @(negedge clock);
        check("t4_err_sticky", 32'(err_timeout), 32'd1);
        step();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        @(negedge clock);
        check("t4_err_clear", 32'(err_timeout), 32'd0);

        // reset in the middle of a stalled transfer
        step();
        m_address[WA +: WA] = 16'h0070;
        m_read = 2'b10;
        repeat (3) @(negedge clock);
        check("t5_busy", 32'(grant), 32'd2);
        step();
        sreset = 1'b1;
        step();
        sreset    = 1'b0;
        stall_cfg = 0;
        m_address[0 +: WA] = 16'h0060;
        m_read = 2'b11;
        expect_xfer(2'b01, 16'h0060, 1'b0, 32'hA5A5_0060);
        expect_xfer(2'b10, 16'h0070, 1'b0, 32'hA5A5_0070);
        @(negedge clock);
        check("t5_rst_grant", 32'(grant), 32'd0);
        check("t5_rst_s_read", 32'(s_read), 32'd0);
        wait_done(0, st);
        step();
        m_read[0] = 1'b0;
        wait_done(1, st);
        step();
        m_read = '0;

        // m0 abandons its read mid-stall, m1 is served next
        step();
        stall_cfg = 1000;
        m_address = {16'h0090, 16'h0080};
        m_read    = 2'b11;
        expect_xfer(2'b10, 16'h0090, 1'b0, 32'hA5A5_0090);
        @(negedge clock);
        @(negedge clock);
        check("t6_grant", 32'(grant), 32'd1);
        check("t6_s_read", 32'(s_read), 32'd1);
        step();
        m_read[0] = 1'b0;
        stall_cfg = 1;
        @(negedge clock);
        check("t6_abandon", 32'(s_read), 32'd0);
        check("t6_abandon_mwr", 32'(m_waitrequest), 32'd2);
        step();
        @(negedge clock);
        check("t6_idle", 32'(grant), 32'd0);
        wait_done(1, st);
        check("t6_m1_stalls", 32'(st), 32'd1);
        step();
        m_read = '0;
        @(negedge clock);
        check("final_sb_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
